// File: rtl/br_pred_if.sv
// Fetch-side lookup and EXE-side update signals of the branch predictor.
// The master modport drives requests; the slave modport is the predictor.
interface br_pred_if #(
    parameter int unsigned PC_SZ = 32
);
    logic             pf_valid_in;
    logic [PC_SZ-1:0] pf_pc_in;
    logic             hold_in;
    logic             flush_in;
    logic             pred_valid_out;
    logic             pred_taken_out;
    logic [PC_SZ-1:0] pred_pc_out;

    logic             upd_valid_in;
    logic [PC_SZ-1:0] upd_pc_in;
    logic             upd_taken_in;
    logic [PC_SZ-1:0] upd_next_pc_in;
    logic [PC_SZ-1:0] upd_pred_pc_in;
    logic             mispredict_out;
    logic [PC_SZ-1:0] redirect_pc_out;
    logic [31:0]      br_cnt_out;
    logic [31:0]      mis_cnt_out;

    modport master (
        output pf_valid_in, pf_pc_in, hold_in, flush_in,
        output upd_valid_in, upd_pc_in, upd_taken_in, upd_next_pc_in, upd_pred_pc_in,
        input  pred_valid_out, pred_taken_out, pred_pc_out,
        input  mispredict_out, redirect_pc_out, br_cnt_out, mis_cnt_out
    );

    modport slave (
        input  pf_valid_in, pf_pc_in, hold_in, flush_in,
        input  upd_valid_in, upd_pc_in, upd_taken_in, upd_next_pc_in, upd_pred_pc_in,
        output pred_valid_out, pred_taken_out, pred_pc_out,
        output mispredict_out, redirect_pc_out, br_cnt_out, mis_cnt_out
    );
endinterface

// File: rtl/br_pred.sv
// Direct-mapped branch target buffer with 2-bit counters: one-cycle lookup,
// update from EXE, registered mispredict redirect and branch statistics.
module br_pred #(
    parameter int unsigned PC_SZ   = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned C_EXT   = 0
) (
    input logic       clk_in,
    input logic       reset_in,
    br_pred_if.slave  bp
);
    localparam int unsigned IDX    = $clog2(ENTRIES);
    localparam int unsigned B      = (C_EXT != 0) ? 1 : 2;
    localparam int unsigned TAG_SZ = PC_SZ - IDX - B;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_SZ-1:0]  tag_q    [ENTRIES];
    logic [PC_SZ-1:0]   target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [PC_SZ-1:0] pred_pc_q;
    logic             mispredict_q;
    logic [PC_SZ-1:0] redirect_pc_q;
    logic [31:0]      br_cnt_q;
    logic [31:0]      mis_cnt_q;

    logic [IDX-1:0]    lk_idx;
    logic [TAG_SZ-1:0] lk_tag;
    logic              lk_hit;
    logic              lk_taken;
    logic [PC_SZ-1:0]  lk_pc;

    logic [IDX-1:0]    up_idx;
    logic [TAG_SZ-1:0] up_tag;
    logic              up_hit;
    logic [1:0]        up_ctr;
    logic              up_mis;

    always_comb begin
        lk_idx   = bp.pf_pc_in[IDX+B-1:B];
        lk_tag   = bp.pf_pc_in[PC_SZ-1:IDX+B];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][1];
        lk_pc    = lk_taken ? target_q[lk_idx] : bp.pf_pc_in + PC_SZ'(4);
    end

    always_comb begin
        up_idx = bp.upd_pc_in[IDX+B-1:B];
        up_tag = bp.upd_pc_in[PC_SZ-1:IDX+B];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr = ctr_q[up_idx];
        if (bp.upd_taken_in) begin
            if (up_ctr != 2'b11) up_ctr = up_ctr + 2'd1;
        end else begin
            if (up_ctr != 2'b00) up_ctr = up_ctr - 2'd1;
        end
        up_mis = bp.upd_valid_in && (bp.upd_pred_pc_in != bp.upd_next_pc_in);
    end

    // Lookup reads the pre-update entry since the table only changes at the edge.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (bp.upd_valid_in) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr;
                if (bp.upd_taken_in) target_q[up_idx] <= bp.upd_next_pc_in;
            end else if (bp.upd_taken_in) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bp.upd_next_pc_in;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

    // Flush wins over hold; hold freezes every prediction output.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
        end else if (bp.flush_in) begin
            pred_valid_q <= 1'b0;
        end else if (!bp.hold_in) begin
            pred_valid_q <= bp.pf_valid_in;
            if (bp.pf_valid_in) begin
                pred_taken_q <= lk_taken;
                pred_pc_q    <= lk_pc;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            mispredict_q <= up_mis;
            if (up_mis) redirect_pc_q <= bp.upd_next_pc_in;
            if (bp.upd_valid_in && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
            if (up_mis && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign bp.pred_valid_out  = pred_valid_q;
    assign bp.pred_taken_out  = pred_taken_q;
    assign bp.pred_pc_out     = pred_pc_q;
    assign bp.mispredict_out  = mispredict_q;
    assign bp.redirect_pc_out = redirect_pc_q;
    assign bp.br_cnt_out      = br_cnt_q;
    assign bp.mis_cnt_out     = mis_cnt_q;
endmodule

// File: tb/tb_br_pred.sv
// Directed table-driven bench for br_pred (ENTRIES=16, C_EXT=0, PC_SZ=32),
// followed by hand sequences for mid-run reset and same-cycle lookup/update.
module tb_br_pred;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam int NVEC = 32;

    typedef struct {
        logic        pfv;
        logic [31:0] pc;
        logic        hold;
        logic        flush;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] unext;
        logic [31:0] upred;
        logic        epv;
        logic        etk;
        logic [31:0] epc;
        logic        emis;
        logic [31:0] eredir;
        logic [31:0] ebr;
        logic [31:0] emc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs [NVEC];

    br_pred_if #(.PC_SZ(32)) bp ();

    br_pred #(.PC_SZ(32), .ENTRIES(16), .C_EXT(0)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bp       (bp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bp.pf_valid_in    = v.pfv;
        bp.pf_pc_in       = v.pc;
        bp.hold_in        = v.hold;
        bp.flush_in       = v.flush;
        bp.upd_valid_in   = v.uv;
        bp.upd_pc_in      = v.upc;
        bp.upd_taken_in   = v.ut;
        bp.upd_next_pc_in = v.unext;
        bp.upd_pred_pc_in = v.upred;
    endtask

    task automatic idle();
        vec_t v;
        v = '{O, 32'h0, O, O, O, 32'h0, O, 32'h0, 32'h0, O, O, 32'h0, O, 32'h0, 32'h0, 32'h0};
        drive(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pred_valid"}, 32'(bp.pred_valid_out), 32'd0);
        chk({tag, " pred_taken"}, 32'(bp.pred_taken_out), 32'd0);
        chk({tag, " pred_pc"}, bp.pred_pc_out, 32'd0);
        chk({tag, " mispredict"}, 32'(bp.mispredict_out), 32'd0);
        chk({tag, " redirect"}, bp.redirect_pc_out, 32'd0);
        chk({tag, " br_cnt"}, bp.br_cnt_out, 32'd0);
        chk({tag, " mis_cnt"}, bp.mis_cnt_out, 32'd0);
    endtask

    // One cycle: drive, clock, then compare the single-pred fields.
    task automatic lookup_chk(input string tag, input logic [31:0] pc, input logic etk,
                              input logic [31:0] epc);
        idle();
        bp.pf_valid_in = 1'b1;
        bp.pf_pc_in    = pc;
        @(posedge clk);
        #1;
        chk({tag, " pred_valid"}, 32'(bp.pred_valid_out), 32'd1);
        chk({tag, " pred_taken"}, 32'(bp.pred_taken_out), 32'(etk));
        chk({tag, " pred_pc"}, bp.pred_pc_out, epc);
    endtask

    initial begin
        //          pfv pc            hold flush uv upc           ut unext         upred
        //          epv etk epc          emis eredir       ebr     emc
        vecs[0]  = '{I, 32'h100, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, O, 32'h104, O, 32'h0, 32'd0, 32'd0};
        vecs[1]  = '{O, 32'h0, O, O, I, 32'h100, I, 32'h200, 32'h104,
                     O, O, 32'h0, I, 32'h200, 32'd1, 32'd1};
        vecs[2]  = '{I, 32'h100, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h200, O, 32'h200, 32'd1, 32'd1};
        vecs[3]  = '{O, 32'h0, O, O, I, 32'h100, I, 32'h200, 32'h200,
                     O, O, 32'h0, O, 32'h200, 32'd2, 32'd1};
        vecs[4]  = '{O, 32'h0, O, O, I, 32'h100, I, 32'h200, 32'h200,
                     O, O, 32'h0, O, 32'h200, 32'd3, 32'd1};
        vecs[5]  = '{O, 32'h0, O, O, I, 32'h100, I, 32'h200, 32'h200,
                     O, O, 32'h0, O, 32'h200, 32'd4, 32'd1};
        vecs[6]  = '{O, 32'h0, O, O, I, 32'h100, O, 32'h104, 32'h200,
                     O, O, 32'h0, I, 32'h104, 32'd5, 32'd2};
        vecs[7]  = '{I, 32'h100, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h200, O, 32'h104, 32'd5, 32'd2};
        vecs[8]  = '{O, 32'h0, O, O, I, 32'h100, O, 32'h104, 32'h104,
                     O, O, 32'h0, O, 32'h104, 32'd6, 32'd2};
        vecs[9]  = '{I, 32'h100, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, O, 32'h104, O, 32'h104, 32'd6, 32'd2};
        vecs[10] = '{O, 32'h0, O, O, I, 32'h100, O, 32'h104, 32'h104,
                     O, O, 32'h0, O, 32'h104, 32'd7, 32'd2};
        vecs[11] = '{I, 32'h140, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, O, 32'h144, O, 32'h104, 32'd7, 32'd2};
        vecs[12] = '{O, 32'h0, O, O, I, 32'h100, O, 32'h104, 32'h104,
                     O, O, 32'h0, O, 32'h104, 32'd8, 32'd2};
        vecs[13] = '{O, 32'h0, O, O, I, 32'h100, I, 32'h200, 32'h104,
                     O, O, 32'h0, I, 32'h200, 32'd9, 32'd3};
        vecs[14] = '{I, 32'h100, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, O, 32'h104, O, 32'h200, 32'd9, 32'd3};
        vecs[15] = '{O, 32'h0, O, O, I, 32'h140, O, 32'h144, 32'h144,
                     O, O, 32'h0, O, 32'h200, 32'd10, 32'd3};
        vecs[16] = '{I, 32'h140, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, O, 32'h144, O, 32'h200, 32'd10, 32'd3};
        vecs[17] = '{I, 32'hFFFF_FFFC, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, O, 32'h0, O, 32'h200, 32'd10, 32'd3};
        vecs[18] = '{O, 32'h0, O, O, I, 32'hFFFF_FFFC, I, 32'h10, 32'h10,
                     O, O, 32'h0, O, 32'h200, 32'd11, 32'd3};
        vecs[19] = '{I, 32'hFFFF_FFFC, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h10, O, 32'h200, 32'd11, 32'd3};
        vecs[20] = '{O, 32'h0, O, O, I, 32'h100, I, 32'h300, 32'h104,
                     O, O, 32'h0, I, 32'h300, 32'd12, 32'd4};
        vecs[21] = '{O, 32'h0, O, O, I, 32'h140, O, 32'h144, 32'h500,
                     O, O, 32'h0, I, 32'h144, 32'd13, 32'd5};
        vecs[22] = '{O, 32'h0, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     O, O, 32'h0, O, 32'h144, 32'd13, 32'd5};
        vecs[23] = '{I, 32'h100, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h300, O, 32'h144, 32'd13, 32'd5};
        vecs[24] = '{I, 32'h140, I, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h300, O, 32'h144, 32'd13, 32'd5};
        vecs[25] = '{I, 32'h140, I, O, I, 32'h140, I, 32'h700, 32'h144,
                     I, I, 32'h300, I, 32'h700, 32'd14, 32'd6};
        vecs[26] = '{I, 32'h140, I, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h300, O, 32'h700, 32'd14, 32'd6};
        vecs[27] = '{I, 32'h140, I, I, O, 32'h0, O, 32'h0, 32'h0,
                     O, O, 32'h0, O, 32'h700, 32'd14, 32'd6};
        vecs[28] = '{I, 32'h140, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h700, O, 32'h700, 32'd14, 32'd6};
        vecs[29] = '{I, 32'h100, O, I, O, 32'h0, O, 32'h0, 32'h0,
                     O, O, 32'h0, O, 32'h700, 32'd14, 32'd6};
        vecs[30] = '{I, 32'h140, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     I, I, 32'h700, O, 32'h700, 32'd14, 32'd6};
        vecs[31] = '{O, 32'h0, O, O, O, 32'h0, O, 32'h0, 32'h0,
                     O, O, 32'h0, O, 32'h700, 32'd14, 32'd6};

        idle();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d pred_valid", i), 32'(bp.pred_valid_out), 32'(vecs[i].epv));
            if (vecs[i].epv) begin
                chk($sformatf("row%0d pred_taken", i), 32'(bp.pred_taken_out),
                    32'(vecs[i].etk));
                chk($sformatf("row%0d pred_pc", i), bp.pred_pc_out, vecs[i].epc);
            end
            chk($sformatf("row%0d mispredict", i), 32'(bp.mispredict_out), 32'(vecs[i].emis));
            chk($sformatf("row%0d redirect", i), bp.redirect_pc_out, vecs[i].eredir);
            chk($sformatf("row%0d br_cnt", i), bp.br_cnt_out, vecs[i].ebr);
            chk($sformatf("row%0d mis_cnt", i), bp.mis_cnt_out, vecs[i].emc);
        end

        // Mid-cycle reset with a lookup and a taken update in flight.
        bp.pf_valid_in    = 1'b1;
        bp.pf_pc_in       = 32'h140;
        bp.upd_valid_in   = 1'b1;
        bp.upd_pc_in      = 32'h180;
        bp.upd_taken_in   = 1'b1;
        bp.upd_next_pc_in = 32'h900;
        bp.upd_pred_pc_in = 32'h184;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        lookup_chk("post_reset 0x140", 32'h140, 1'b0, 32'h144);
        lookup_chk("post_reset 0x180", 32'h180, 1'b0, 32'h184);
        chk("post_reset br_cnt", bp.br_cnt_out, 32'd0);
        chk("post_reset mis_cnt", bp.mis_cnt_out, 32'd0);

        // Lookup and first taken update of the same PC in one cycle.
        bp.upd_valid_in   = 1'b1;
        bp.upd_pc_in      = 32'h300;
        bp.upd_taken_in   = 1'b1;
        bp.upd_next_pc_in = 32'h380;
        bp.upd_pred_pc_in = 32'h304;
        bp.pf_valid_in    = 1'b1;
        bp.pf_pc_in       = 32'h300;
        @(posedge clk);
        #1;
        chk("same_cycle pred_valid", 32'(bp.pred_valid_out), 32'd1);
        chk("same_cycle pred_taken", 32'(bp.pred_taken_out), 32'd0);
        chk("same_cycle pred_pc", bp.pred_pc_out, 32'h304);
        chk("same_cycle mispredict", 32'(bp.mispredict_out), 32'd1);
        chk("same_cycle redirect", bp.redirect_pc_out, 32'h380);
        chk("same_cycle br_cnt", bp.br_cnt_out, 32'd1);
        chk("same_cycle mis_cnt", bp.mis_cnt_out, 32'd1);
        lookup_chk("after_same_cycle 0x300", 32'h300, 1'b1, 32'h380);
        chk("after_same_cycle mispredict", 32'(bp.mispredict_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/br_pred.md
BR_PRED -- requirements
Module: br_pred

Interface
REQ-001 Parameter PC_SZ, default 32: width of all PC/target values.
REQ-002 Parameter ENTRIES, default 16: branch-table depth; SHALL be a power of 2, >= 2; IDX = log2(ENTRIES).
REQ-003 Parameter C_EXT, default 0: 1 = compressed ISA, so the index base bit B=1; 0 means B=2.
REQ-004 clk_in  input  1  sole clock, rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 pf_valid_in  input  1  lookup request this cycle.
REQ-007 pf_pc_in  input  PC_SZ  fetch PC to predict.
REQ-008 hold_in  input  1  freeze prediction outputs.
REQ-009 flush_in  input  1  discard the pending prediction.
REQ-010 pred_valid_out  output  1  prediction valid.
REQ-011 pred_taken_out  output  1  predicted taken.
REQ-012 pred_pc_out  output  PC_SZ  predicted next PC.
REQ-013 upd_valid_in  input  1  resolved branch/jump from EXE.
REQ-014 upd_pc_in  input  PC_SZ  PC of the resolved instruction.
REQ-015 upd_taken_in  input  1  actual direction.
REQ-016 upd_next_pc_in  input  PC_SZ  actual next PC (br_pc when taken, else no_br_pc).
REQ-017 upd_pred_pc_in  input  PC_SZ  next PC predicted for this instruction.
REQ-018 mispredict_out  output  1  one-cycle redirect pulse.
REQ-019 redirect_pc_out  output  PC_SZ  correct PC on mispredict.
REQ-020 br_cnt_out  output  32  resolved-branch count.
REQ-021 mis_cnt_out  output  32  mispredict count.

Function
REQ-022 Table entry SHALL hold: valid, tag = pc[PC_SZ-1:IDX+B], target[PC_SZ], 2-bit counter ctr.
REQ-023 Index SHALL be pc[IDX+B-1:B] for both lookup and update.
REQ-024 Hit SHALL mean entry valid and tag equal.
REQ-025 Lookup SHALL take 1 cycle: on the edge where pf_valid_in=1, hold_in=0 and flush_in=0, register pred_valid_out=1.
REQ-026 On a hit with ctr[1]=1, the registered prediction SHALL be pred_taken_out=1 and pred_pc_out=target.
REQ-027 Otherwise the registered prediction SHALL be pred_taken_out=0 and pred_pc_out=pf_pc_in+4, truncated to PC_SZ.
REQ-028 When pf_valid_in=0, hold_in=0 and flush_in=0, the next edge SHALL set pred_valid_out=0; other prediction outputs are don't-care.
REQ-029 hold_in=1 SHALL keep all pred_* outputs unchanged; hold_in SHALL NOT block updates.
REQ-030 flush_in=1 SHALL clear pred_valid_out on the next edge.
REQ-031 flush_in SHALL override hold_in.
REQ-032 flush_in SHALL NOT alter table contents.
REQ-033 Update on a hit: ctr SHALL saturate-increment if upd_taken_in, else saturate-decrement (ctr=11 +1 -> 11; ctr=00 -1 -> 00).
REQ-034 Update on a hit with upd_taken_in=1: target SHALL be written with upd_next_pc_in.
REQ-035 Update on a miss with upd_taken_in=1: the entry SHALL be allocated (overwriting) with valid=1, tag, target=upd_next_pc_in, ctr=10.
REQ-036 Update on a miss with upd_taken_in=0: the table SHALL NOT change.
REQ-037 A lookup and an update to the same index in one cycle SHALL make the lookup see the pre-update entry; the update SHALL still commit.
REQ-038 mispredict_out SHALL be registered: high for exactly the cycle after an update where upd_pred_pc_in != upd_next_pc_in.
REQ-039 redirect_pc_out SHALL equal the registered upd_next_pc_in from that update.
REQ-040 redirect_pc_out SHALL hold its value otherwise.
REQ-041 Back-to-back mispredicting updates SHALL give consecutive mispredict pulses, each with its own redirect PC.
REQ-042 br_cnt_out SHALL increment per upd_valid_in and saturate at 0xFFFFFFFF.
REQ-043 mis_cnt_out SHALL increment per mispredict and saturate at 0xFFFFFFFF.
REQ-044 pred_pc_out and target arithmetic SHALL wrap modulo 2^PC_SZ.

Reset
REQ-045 reset_in=1 SHALL asynchronously clear all entries to valid=0 and ctr=01.
REQ-046 reset_in=1 SHALL asynchronously force pred_valid_out, pred_taken_out, pred_pc_out, mispredict_out, redirect_pc_out, br_cnt_out and mis_cnt_out to 0.
REQ-047 An update or lookup in flight at reset assertion SHALL be lost.
REQ-048 The first edge after reset deassertion SHALL behave as a normal cycle.

Verification
REQ-049 Reset, then lookup pc=0x100 -> next cycle pred_valid_out=1, taken=0, pred_pc_out=0x104.
REQ-050 Update pc=0x100, taken, next=0x200, pred=0x104 -> next cycle mispredict_out=1, redirect=0x200, mis_cnt=1, br_cnt=1; then lookup 0x100 -> taken=1, pred_pc=0x200.
REQ-051 Four taken updates to 0x100, then three not-taken -> ctr path 10,11,11,11,10,01,00; lookup after the first not-taken still predicts taken, and the lookup after the second predicts not-taken.
REQ-052 ENTRIES=16, C_EXT=0: update taken 0x100 -> 0x200, then lookup 0x140 (same index, other tag) -> miss, pred_pc=0x144.
REQ-053 Same-cycle lookup and first taken update of 0x300 -> lookup predicts not-taken; the next lookup of 0x300 predicts taken.
REQ-054 hold_in=1 for 3 cycles with new lookups -> outputs frozen; flush_in with hold_in=1 -> pred_valid_out=0; reset mid-run -> all outputs 0 and table empty.
